// File: rtl/pulp_board_io.sv
// Board I/O conditioning: input synchronise/debounce with edge pulses,
// stretched synchronous SoC reset from the board reset button, and LED drive
// with off/on/follow/blink modes.
module pulp_board_io #(
  parameter int unsigned N_IN            = 8,
  parameter int unsigned N_LED           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned RST_STRETCH     = 16,
  parameter int unsigned BLINK_CYCLES    = 25000000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pad_reset_i,
  input  logic [N_IN-1:0]    in_raw_i,
  output logic [N_IN-1:0]    in_o,
  output logic [N_IN-1:0]    rise_o,
  output logic [N_IN-1:0]    fall_o,
  output logic               soc_rst_no,
  input  logic [2*N_LED-1:0] led_mode_i,
  input  logic [N_LED-1:0]   led_i,
  output logic [N_LED-1:0]   led_o
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned StW = $clog2(RST_STRETCH + 1);
  localparam int unsigned BlW = $clog2(BLINK_CYCLES + 1);

  localparam logic [DbW-1:0] DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [StW-1:0] StDone   = StW'(RST_STRETCH);
  localparam logic [BlW-1:0] BlLast   = BlW'(BLINK_CYCLES - 1);

  // Debounce state
  logic [N_IN-1:0][SYNC_STAGES-1:0] in_sync_q, in_sync_d;
  logic [N_IN-1:0][DbW-1:0]         db_cnt_q, db_cnt_d;
  logic [N_IN-1:0]                  in_q, in_d;
  logic [N_IN-1:0]                  rise_q, rise_d;
  logic [N_IN-1:0]                  fall_q, fall_d;

  // Reset generator state
  logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
  logic [StW-1:0]         rst_cnt_q, rst_cnt_d;
  logic                   soc_rst_q, soc_rst_d;

  // LED state
  logic [BlW-1:0]   blink_cnt_q, blink_cnt_d;
  logic             blink_q, blink_d;
  logic [N_LED-1:0] led_q, led_d;

  // Per-channel synchroniser shift and debounce counter; edge pulses coincide with the in_o update.
  always_comb begin
    in_sync_d = in_sync_q;
    db_cnt_d  = '0;
    in_d      = in_q;
    rise_d    = '0;
    fall_d    = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      in_sync_d[i] = {in_sync_q[i][SYNC_STAGES-2:0], in_raw_i[i]};
      if (in_sync_q[i][SYNC_STAGES-1] != in_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          in_d[i]   = in_sync_q[i][SYNC_STAGES-1];
          rise_d[i] = in_sync_q[i][SYNC_STAGES-1];
          fall_d[i] = ~in_sync_q[i][SYNC_STAGES-1];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Reset stretch: soc_rst is registered from the next-state values so the
  // output is a clean flop that drops SYNC_STAGES edges after a press.
  always_comb begin
    rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], pad_reset_i};
    rst_cnt_d  = rst_cnt_q;
    if (rst_sync_q[SYNC_STAGES-1]) begin
      rst_cnt_d = '0;
    end else if (rst_cnt_q < StDone) begin
      rst_cnt_d = rst_cnt_q + 1'b1;
    end
    soc_rst_d = ~rst_sync_d[SYNC_STAGES-1] && (rst_cnt_d == StDone);
  end

  // Free-running blink phase and per-LED mode select.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_d     = blink_q;
    if (blink_cnt_q == BlLast) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
    led_d = '0;
    for (int i = 0; i < int'(N_LED); i++) begin
      unique case (led_mode_i[2*i +: 2])
        2'b00:   led_d[i] = 1'b0;
        2'b01:   led_d[i] = 1'b1;
        2'b10:   led_d[i] = led_i[i];
        default: led_d[i] = blink_q;
      endcase
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_sync_q   <= '0;
      db_cnt_q    <= '0;
      in_q        <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      rst_sync_q  <= '0;
      rst_cnt_q   <= '0;
      soc_rst_q   <= 1'b0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      led_q       <= '0;
    end else begin
      in_sync_q   <= in_sync_d;
      db_cnt_q    <= db_cnt_d;
      in_q        <= in_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      rst_sync_q  <= rst_sync_d;
      rst_cnt_q   <= rst_cnt_d;
      soc_rst_q   <= soc_rst_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      led_q       <= led_d;
    end
  end

  assign in_o       = in_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign soc_rst_no = soc_rst_q;
  assign led_o      = led_q;

endmodule
